arp_packet_encoder: RTL and testbench

//  Parametrised ARP packet serializer. Sits between the ARP responder/resolver logic and the MAC TX path.

---
 rtl/arp_packet_encoder_pkg.sv | 34 +++
 rtl/arp_packet_encoder.sv | 111 +++++++++++
 tb/tb_arp_packet_encoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_packet_encoder_pkg.sv
// Package arp_pkg: ARP / Ethernet field constants, the transmitter state type
// and the ARP body assembly function shared by the encoder.
//   build_arp_body(sha, spa, is_req, tha, tpa) -> 224-bit big-endian ARP body
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam int          ARP_BODY_BYTES = 28;
  localparam int          ETH_HDR_BYTES  = 14;

  typedef enum logic {ARP_TX_IDLE, ARP_TX_SEND} arp_tx_state_t;

  // Field order on the wire: HTYPE PTYPE HLEN PLEN OPER SHA SPA THA TPA.
  // A request carries an all-zero THA because the target is what we are asking for.
  function automatic logic [ARP_BODY_BYTES*8-1:0] build_arp_body(
    input logic [47:0] sha,
    input logic [31:0] spa,
    input logic        is_req,
    input logic [47:0] tha,
    input logic [31:0] tpa
  );
    logic [15:0] oper;
    logic [47:0] tha_f;
    oper  = is_req ? ARP_OP_REQUEST : ARP_OP_REPLY;
    tha_f = is_req ? 48'h0 : tha;
    return {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN, oper, sha, spa, tha_f, tpa};
  endfunction

endpackage

// File: rtl/arp_packet_encoder.sv
// arp_packet_encoder: accepts one ARP descriptor over valid/ready and serialises
// the packet MSB-first, DATA_W bits per beat, flagging the final beat.
// Optional build macro: ARP_ETH_HDR_EN prepends a 14-byte Ethernet II header
// (dst = req_tha for a reply / broadcast for a request, src = MAC_ADDR, type 0x0806).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   descriptor handshake (ready only while idle)
//   req_op            1 = request, 0 = reply
//   req_tha, req_tpa  target hardware / protocol address
//   out_valid/ready   beat handshake
//   out_data          beat data, DATA_W bits
//   out_last          final beat of the packet
module arp_packet_encoder
  import arp_pkg::*;
#(
  parameter int          DATA_W   = 4,
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter logic [31:0] IP_ADDR  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [47:0]       req_tha,
  input  logic [31:0]       req_tpa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

`ifdef ARP_ETH_HDR_EN
  localparam int PKT_BITS = (ETH_HDR_BYTES + ARP_BODY_BYTES) * 8;
`else
  localparam int PKT_BITS = ARP_BODY_BYTES * 8;
`endif
  localparam int NBEATS = PKT_BITS / DATA_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  generate
    if (DATA_W != 4 && DATA_W != 8 && DATA_W != 16) begin : g_bad_width
      $error("arp_packet_encoder: DATA_W must be 4, 8 or 16");
    end
  endgenerate

  arp_tx_state_t       state_q, state_d;
  logic [PKT_BITS-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [PKT_BITS-1:0] pkt_load;
  logic                accept;
  logic                fire;

  always_comb begin
    pkt_load = '0;
`ifdef ARP_ETH_HDR_EN
    pkt_load = {(req_op ? 48'hFFFF_FFFF_FFFF : req_tha), MAC_ADDR, ETHERTYPE_ARP,
                build_arp_body(MAC_ADDR, IP_ADDR, req_op, req_tha, req_tpa)};
`else
    pkt_load = build_arp_body(MAC_ADDR, IP_ADDR, req_op, req_tha, req_tpa);
`endif
  end

  // Ready is masked by rst so it first rises the cycle after reset is released.
  assign req_ready = (state_q == ARP_TX_IDLE) && !rst;
  assign out_valid = (state_q == ARP_TX_SEND);
  assign out_data  = out_valid ? sreg_q[PKT_BITS-1 -: DATA_W] : '0;
  assign out_last  = out_valid && (beat_q == LAST_BEAT);
  assign accept    = req_valid && req_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    beat_d  = beat_q;
    case (state_q)
      ARP_TX_IDLE: begin
        if (accept) begin
          state_d = ARP_TX_SEND;
          sreg_d  = pkt_load;
          beat_d  = '0;
        end
      end
      ARP_TX_SEND: begin
        if (fire) begin
          sreg_d = sreg_q << DATA_W;
          beat_d = beat_q + 1'b1;
          if (out_last) state_d = ARP_TX_IDLE;
        end
      end
      default: state_d = ARP_TX_IDLE;
    endcase
  end

  // Control state is reset; the shift register is only read while sending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARP_TX_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
  end

endmodule

// File: tb/tb_arp_packet_encoder.sv
module tb_arp_packet_encoder;

  localparam logic [47:0] MAC = 48'h0200_0000_0001;
  localparam logic [31:0] IP  = 32'hC0A8_0001;
  localparam logic [47:0] THA = 48'hAABB_CCDD_EEFF;
  localparam logic [31:0] TPA = 32'hC0A8_0002;
`ifdef ARP_ETH_HDR_EN
  localparam int PKT = 336;
  localparam int HB  = 14;
`else
  localparam int PKT = 224;
  localparam int HB  = 0;
`endif
  localparam int NB4  = PKT / 4;
  localparam int NB8  = PKT / 8;
  localparam int NB16 = PKT / 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_op = 1'b0;
  logic [47:0] req_tha = '0;
  logic [31:0] req_tpa = '0;
  logic        req_valid4 = 0, req_valid8 = 0, req_valid16 = 0;
  logic        req_ready4, req_ready8, req_ready16;
  logic        out_valid4, out_valid8, out_valid16;
  logic        out_ready4 = 1, out_ready8 = 1, out_ready16 = 1;
  logic [3:0]  out_data4;
  logic [7:0]  out_data8;
  logic [15:0] out_data16;
  logic        out_last4, out_last8, out_last16;

  arp_packet_encoder #(.DATA_W(4), .MAC_ADDR(MAC), .IP_ADDR(IP)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op),
    .req_tha(req_tha), .req_tpa(req_tpa), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_last(out_last4));

  arp_packet_encoder #(.DATA_W(8), .MAC_ADDR(MAC), .IP_ADDR(IP)) u_dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid8), .req_ready(req_ready8), .req_op(req_op),
    .req_tha(req_tha), .req_tpa(req_tpa), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_last(out_last8));

  arp_packet_encoder #(.DATA_W(16), .MAC_ADDR(MAC), .IP_ADDR(IP)) u_dut16 (
    .clk(clk), .rst(rst), .req_valid(req_valid16), .req_ready(req_ready16), .req_op(req_op),
    .req_tha(req_tha), .req_tpa(req_tpa), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .out_last(out_last16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference packet built from the field list; packet occupies bits [PKT-1:0].
  function automatic logic [335:0] model(input logic op, input logic [47:0] tha, input logic [31:0] tpa);
    logic [223:0] body;
    logic [335:0] r;
    body = {16'h0001, 16'h0800, 8'h06, 8'h04, (op ? 16'h0001 : 16'h0002), MAC, IP,
            (op ? 48'h0 : tha), tpa};
`ifdef ARP_ETH_HDR_EN
    r = {(op ? 48'hFFFF_FFFF_FFFF : tha), MAC, 16'h0806, body};
`else
    r = {112'h0, body};
`endif
    return r;
  endfunction

  // ---------------- DATA_W=8 monitor with scoreboard ----------------
  typedef struct packed { logic last; logic [7:0] data; } beat8_t;
  beat8_t     exp_q[$];
  logic [7:0] cap8[0:NB8-1];
  logic       lc8[0:NB8-1];
  int cnt8 = 0, acc8 = 0, done8 = 0, cyc = 0, acc_cyc = 0, last_cyc = 0, stalls = 0;
  logic       stall8 = 0;
  logic [7:0] pd8 = '0;
  logic       pl8 = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      cnt8   = 0;
      stall8 = 0;
    end else begin
      if (stall8 && out_valid8) begin
        chk("stall_data", out_data8, pd8);
        chk("stall_last", out_last8, pl8);
      end
      stall8 = out_valid8 && !out_ready8;
      if (stall8) stalls++;
      pd8 = out_data8;
      pl8 = out_last8;
      if (out_valid8) chk("ready_low_in_send", req_ready8, 1'b0);
      if (req_valid8 && req_ready8) begin
        logic [335:0] p;
        p = model(req_op, req_tha, req_tpa);
        for (int i = 0; i < NB8; i++) begin
          beat8_t b;
          b.last = (i == NB8 - 1);
          b.data = p[PKT-1-8*i -: 8];
          exp_q.push_back(b);
        end
        cnt8 = 0;
        acc8++;
        acc_cyc = cyc;
      end
      if (out_valid8 && out_ready8) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got beat %0h expected no beat", out_data8);
        end else begin
          beat8_t e;
          e = exp_q.pop_front();
          chk("sb_data", out_data8, e.data);
          chk("sb_last", out_last8, e.last);
        end
        if (cnt8 < NB8) begin
          cap8[cnt8] = out_data8;
          lc8[cnt8]  = out_last8;
        end
        cnt8++;
        if (out_last8) begin
          done8++;
          last_cyc = cyc;
        end
      end
    end
  end

  // ---------------- DATA_W=4 / 16 capture ----------------
  logic [3:0]  cap4[0:NB4-1];
  logic        lc4[0:NB4-1];
  logic [15:0] cap16[0:NB16-1];
  logic        lc16[0:NB16-1];
  int cnt4 = 0, acc4 = 0, done4 = 0, cnt16 = 0, acc16 = 0, done16 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid4 && req_ready4) begin cnt4 = 0; acc4++; end
      if (out_valid4 && out_ready4) begin
        if (cnt4 < NB4) begin cap4[cnt4] = out_data4; lc4[cnt4] = out_last4; end
        cnt4++;
        if (out_last4) done4++;
      end
      if (req_valid16 && req_ready16) begin cnt16 = 0; acc16++; end
      if (out_valid16 && out_ready16) begin
        if (cnt16 < NB16) begin cap16[cnt16] = out_data16; lc16[cnt16] = out_last16; end
        cnt16++;
        if (out_last16) done16++;
      end
    end
  end

  // Backpressure pattern 1,0,0,1 on the DATA_W=8 sink.
  logic bp_on = 0;
  int   ph = 0;
  logic [3:0] pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    if (bp_on) begin
      out_ready8 = pat[3-ph];
      ph = (ph + 1) % 4;
    end else begin
      out_ready8 = 1'b1;
      ph = 0;
    end
  end

  function automatic int ctr(input int w);
    case (w)
      0: return acc8;
      1: return done8;
      2: return acc4;
      3: return done4;
      4: return acc16;
      5: return done16;
      default: return cnt8;
    endcase
  endfunction

  task automatic wait_ge(input int w, input int target, input string nm);
    int b;
    b = 0;
    while (ctr(w) < target && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (ctr(w) < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: got %0d expected %0d", nm, ctr(w), target);
    end
  endtask

  task automatic send8(input logic op, input logic [47:0] tha, input logic [31:0] tpa);
    int a0, d0;
    a0 = acc8;
    d0 = done8;
    req_op = op; req_tha = tha; req_tpa = tpa;
    req_valid8 = 1'b1;
    wait_ge(0, a0 + 1, "acc8");
    @(posedge clk); #1;
    req_valid8 = 1'b0;
    req_tha = ~tha; req_tpa = ~tpa; req_op = ~op;
    wait_ge(1, d0 + 1, "done8");
  endtask

  typedef struct {
    logic        op;
    logic [47:0] tha;
    logic [31:0] tpa;
    int          beat;
    logic [7:0]  exp;
    logic        exp_last;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] ref_cap[0:NB8-1];

  initial begin
    int bad;
    logic [335:0] p;
    logic [3:0] e4a[4];
    logic [3:0] e4b[4];
    e4a = '{4'h0, 4'h0, 4'h0, 4'h1};
    e4b = '{4'h0, 4'h0, 4'h0, 4'h2};

    vecs[0] = '{1'b1, THA, TPA, 6,  8'h00, 1'b0};
    vecs[1] = '{1'b1, THA, TPA, 7,  8'h01, 1'b0};
    vecs[2] = '{1'b1, THA, TPA, 20, 8'h00, 1'b0};
    vecs[3] = '{1'b1, THA, TPA, 27, 8'h02, 1'b1};
    vecs[4] = '{1'b0, THA, TPA, 7,  8'h02, 1'b0};
    vecs[5] = '{1'b0, THA, TPA, 18, 8'hAA, 1'b0};
    vecs[6] = '{1'b0, THA, TPA, 23, 8'hFF, 1'b0};
    vecs[7] = '{1'b0, 48'h1122_3344_5566, 32'h0A00_0099, 27, 8'h99, 1'b1};
    vecs[8] = '{1'b0, 48'h1122_3344_5566, 32'h0A00_0099, 24, 8'h0A, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready8, 1'b0);
    chk("rst_out_valid", out_valid8, 1'b0);
    chk("rst_out_last",  out_last8,  1'b0);
    chk("rst_out_data",  out_data8,  8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready8, 1'b1);
    chk("ready_after_rst16", req_ready16, 1'b1);

    // DATA_W=4 reply
    req_op = 1'b0; req_tha = THA; req_tpa = TPA;
    req_valid4 = 1'b1;
    wait_ge(2, 1, "acc4");
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    @(negedge clk);
    chk("dw4_valid_after_accept", out_valid4, 1'b1);
    wait_ge(3, 1, "done4");
    chk("dw4_count", cnt4, NB4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dw4_beat%0d", i), cap4[2*HB + i], e4a[i]);
      chk($sformatf("dw4_beat%0d", 12 + i), cap4[2*HB + 12 + i], e4b[i]);
    end
    chk("dw4_beat36", cap4[2*HB + 36], 4'hA);
    chk("dw4_beat55", cap4[2*HB + 55], 4'h2);
    chk("dw4_last55", lc4[2*HB + 55], 1'b1);
    p = model(1'b0, THA, TPA);
    bad = 0;
    for (int i = 0; i < NB4; i++)
      if (cap4[i] !== p[PKT-1-4*i -: 4] || lc4[i] !== (i == NB4 - 1)) bad++;
    chk("dw4_stream_errs", bad, 0);

    // DATA_W=8 table
    for (int v = 0; v < 9; v++) begin
      send8(vecs[v].op, vecs[v].tha, vecs[v].tpa);
      chk($sformatf("vec%0d_count", v), cnt8, NB8);
      chk($sformatf("vec%0d_beat%0d", v, vecs[v].beat), cap8[HB + vecs[v].beat], vecs[v].exp);
      chk($sformatf("vec%0d_last", v), lc8[HB + vecs[v].beat], vecs[v].exp_last);
      if (v == 0) for (int i = 0; i < NB8; i++) ref_cap[i] = cap8[i];
      @(negedge clk);
    end

    // Backpressure: same stream as the first request vector
    bp_on = 1'b1;
    send8(1'b1, THA, TPA);
    bp_on = 1'b0;
    chk("bp_count", cnt8, NB8);
    chk("bp_stalled", stalls > 0, 1'b1);
    bad = 0;
    for (int i = 0; i < NB8; i++) if (cap8[i] !== ref_cap[i]) bad++;
    chk("bp_stream_errs", bad, 0);

    // Back-to-back with req_valid held
    begin
      int a0;
      a0 = acc8;
      req_op = 1'b1; req_tha = THA; req_tpa = TPA;
      req_valid8 = 1'b1;
      wait_ge(0, a0 + 1, "b2b_acc1");
      @(posedge clk); #1;
      req_op = 1'b0; req_tpa = 32'h0A0B_0C0D;
      wait_ge(0, a0 + 2, "b2b_acc2");
      chk("b2b_gap", acc_cyc - last_cyc, 1);
      @(posedge clk); #1;
      req_valid8 = 1'b0;
      wait_ge(1, done8 + 1, "b2b_done2");
      chk("b2b_tpa_low", cap8[NB8-1], 8'h0D);
    end

    // Reset in the middle of a packet
    req_op = 1'b1; req_tha = THA; req_tpa = TPA;
    req_valid8 = 1'b1;
    wait_ge(0, acc8 + 1, "rst_acc");
    @(posedge clk); #1;
    req_valid8 = 1'b0;
    wait_ge(6, 10, "beat10");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_low", req_ready8, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_low", out_valid8, 1'b0);
    chk("midrst_ready_high", req_ready8, 1'b1);
    send8(1'b1, THA, TPA);
    chk("midrst_count", cnt8, NB8);
    chk("midrst_beat0", cap8[0], (HB != 0) ? 8'hFF : 8'h00);

    // DATA_W=16 request
    req_op = 1'b1; req_tha = THA; req_tpa = TPA;
    req_valid16 = 1'b1;
    wait_ge(4, 1, "acc16");
    @(posedge clk); #1;
    req_valid16 = 1'b0;
    wait_ge(5, 1, "done16");
    chk("dw16_count", cnt16, NB16);
`ifdef ARP_ETH_HDR_EN
    for (int i = 0; i < 3; i++) chk($sformatf("dw16_beat%0d", i), cap16[i], 16'hFFFF);
    chk("dw16_beat6", cap16[6], 16'h0806);
    chk("dw16_beat20", cap16[20], 16'h0002);
    chk("dw16_last20", lc16[20], 1'b1);
`else
    chk("dw16_beat0", cap16[0], 16'h0001);
    chk("dw16_beat3", cap16[3], 16'h0001);
    chk("dw16_beat13", cap16[13], 16'h0002);
    chk("dw16_last13", lc16[13], 1'b1);
`endif
    p = model(1'b1, THA, TPA);
    bad = 0;
    for (int i = 0; i < NB16; i++)
      if (cap16[i] !== p[PKT-1-16*i -: 16] || lc16[i] !== (i == NB16 - 1)) bad++;
    chk("dw16_stream_errs", bad, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
